// File: rtl/reg_file_mp.sv
// Multi-port register file: two write ports, three async read ports and a per-register busy scoreboard.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data (and busy clear) onto the read ports.
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWr0,
  input  logic [ADDR_W-1:0] Rw0,
  input  logic [DATA_W-1:0] busW0,
  input  logic              RegWr1,
  input  logic [ADDR_W-1:0] Rw1,
  input  logic [DATA_W-1:0] busW1,
  input  logic [ADDR_W-1:0] Ra,
  input  logic [ADDR_W-1:0] Rb,
  input  logic [ADDR_W-1:0] Rc,
  output logic [DATA_W-1:0] busA,
  output logic [DATA_W-1:0] busB,
  output logic [DATA_W-1:0] busC,
  input  logic              RsvEn,
  input  logic [ADDR_W-1:0] RsvAddr,
  output logic              busyA,
  output logic              busyB,
  output logic              busyC,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   busy_cnt_q, busy_cnt_d;

  logic [ADDR_W-1:0] rd_addr [3];
  logic [DATA_W-1:0] rd_data [3];
  logic              rd_busy [3];

  function automatic logic is_zero(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
    logic [ADDR_W:0] cnt;
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) cnt = cnt + {{ADDR_W{1'b0}}, v[i]};
    return cnt;
  endfunction

  // Port 1 is applied after port 0 so it wins a collision; a reserve is applied last so it wins over a writeback.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (RegWr0 && !is_zero(Rw0)) begin
      regs_d[Rw0] = busW0;
      busy_d[Rw0] = 1'b0;
    end
    if (RegWr1 && !is_zero(Rw1)) begin
      regs_d[Rw1] = busW1;
      busy_d[Rw1] = 1'b0;
    end
    if (RsvEn && !is_zero(RsvAddr)) busy_d[RsvAddr] = 1'b1;
    busy_cnt_d = popcount(busy_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign rd_addr[0] = Ra;
  assign rd_addr[1] = Rb;
  assign rd_addr[2] = Rc;

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      rd_data[p] = regs_q[rd_addr[p]];
      rd_busy[p] = busy_q[rd_addr[p]];
`ifdef REG_FILE_BYPASS_EN
      // A forwarded value is no longer pending unless a new producer reserves it this same cycle.
      if (RegWr0 && (Rw0 == rd_addr[p])) begin
        rd_data[p] = busW0;
        rd_busy[p] = RsvEn && (RsvAddr == rd_addr[p]);
      end
      if (RegWr1 && (Rw1 == rd_addr[p])) begin
        rd_data[p] = busW1;
        rd_busy[p] = RsvEn && (RsvAddr == rd_addr[p]);
      end
`endif
      if (is_zero(rd_addr[p])) begin
        rd_data[p] = '0;
        rd_busy[p] = 1'b0;
      end
    end
  end

  assign busA     = rd_data[0];
  assign busB     = rd_data[1];
  assign busC     = rd_data[2];
  assign busyA    = rd_busy[0];
  assign busyB    = rd_busy[1];
  assign busyC    = rd_busy[2];
  assign busy_cnt = busy_cnt_q;

endmodule
